// File: rtl/uart_mmio_pkg.sv
// Shared constants, register offsets and FSM state type for the memory-mapped UART transmitter.
package uart_mmio_pkg;

    localparam int unsigned DIV_W    = 16;
    localparam int unsigned OFF_W    = 4;
    localparam int unsigned BYTE_W   = 8;

    localparam logic [OFF_W-1:0] OFF_TXDATA = 4'h0;
    localparam logic [OFF_W-1:0] OFF_STATUS = 4'h4;
    localparam logic [OFF_W-1:0] OFF_DIV    = 4'h8;

    localparam int unsigned ST_BUSY    = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_EMPTY   = 2;
    localparam int unsigned ST_OVF     = 3;
    localparam int unsigned ST_CNT_LSB = 4;
    localparam int unsigned ST_CNT_W   = 3;

    localparam logic [DIV_W-1:0] MIN_DIV = 16'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Divisors below two cannot form a valid bit period.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Small synchronous FIFO holding bytes waiting to be serialised; push while full is
// accepted when a pop happens in the same cycle.
module tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter sitting beside the data RAM on the core's data bus.
module uart_tx_mmio
    import uart_mmio_pkg::*;
#(
    parameter logic [9:0]  BASE_ADDR   = 10'h3F0,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [9:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        hit,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [OFF_W-1:0]  off_c;
    logic              wr_txdata_c, wr_status_c, wr_div_c, push_drop_c;
    logic              fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [BYTE_W-1:0] fifo_rdata;
    logic              unused_wdata;

    logic              ovf_q, ovf_d;
    logic [DIV_W-1:0]  div_q, div_d;
    tx_state_t         state_q, state_d;
    logic [DIV_W-1:0]  bcnt_q, bcnt_d;
    logic [DIV_W-1:0]  div_l_q, div_l_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              bit_end_c;

    assign off_c        = address[OFF_W-1:0];
    assign hit          = (address[9:4] == BASE_ADDR[9:4]);
    assign wr_txdata_c  = MemWrite && hit && (off_c == OFF_TXDATA);
    assign wr_status_c  = MemWrite && hit && (off_c == OFF_STATUS);
    assign wr_div_c     = MemWrite && hit && (off_c == OFF_DIV);
    assign push_drop_c  = wr_txdata_c && fifo_full && !fifo_pop;
    assign unused_wdata = ^write_data[31:DIV_W];

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RSTn),
        .push_i  (wr_txdata_c),
        .pop_i   (fifo_pop),
        .wdata_i (write_data[BYTE_W-1:0]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Control registers; a new overflow beats a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        div_d = div_q;
        if (wr_status_c && write_data[ST_OVF]) ovf_d = 1'b0;
        if (push_drop_c)                       ovf_d = 1'b1;
        if (wr_div_c) div_d = clamp_div(write_data[DIV_W-1:0]);
    end

    assign bit_end_c = (bcnt_q == div_l_q - DIV_W'(1));

    // Serialiser: pops straight into START from IDLE or STOP, so queued frames abut.
    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        div_l_d   = div_l_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        fifo_pop  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_rdata;
                    div_l_d  = div_q;
                    bcnt_d   = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end_c) begin
                    bcnt_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    bcnt_d = bcnt_q + DIV_W'(1);
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    bcnt_d  = '0;
                    shreg_d = {1'b0, shreg_q[BYTE_W-1:1]};
                    if (bit_idx_q == 3'd7) state_d = STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    bcnt_d = bcnt_q + DIV_W'(1);
                end
            end
            STOP: begin
                if (bit_end_c) begin
                    bcnt_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_rdata;
                        div_l_d  = div_q;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bcnt_d = bcnt_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE) || !fifo_empty;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            ovf_q     <= 1'b0;
            div_q     <= DEFAULT_DIV;
            state_q   <= IDLE;
            bcnt_q    <= '0;
            div_l_q   <= DEFAULT_DIV;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            ovf_q     <= ovf_d;
            div_q     <= div_d;
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            div_l_q   <= div_l_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    // Loads see the pre-edge register state, like the RAM beside this block.
    always_comb begin
        read_data = '0;
        if (MemRead && hit) begin
            case (off_c)
                OFF_STATUS: begin
                    read_data[ST_BUSY]                   = busy_q;
                    read_data[ST_FULL]                   = fifo_full;
                    read_data[ST_EMPTY]                  = fifo_empty;
                    read_data[ST_OVF]                    = ovf_q;
                    read_data[ST_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(fifo_count);
                end
                OFF_DIV: read_data[DIV_W-1:0] = div_q;
                default: read_data = '0;
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed and randomised checks of uart_tx_mmio against a frame-level waveform model.
module tb_uart_tx_mmio;

    localparam logic [9:0]  BASE    = 10'h3F0;
    localparam logic [31:0] DEF_DIV = 32'd868;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [9:0]  address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        hit, tx, busy;

    int unsigned passed = 0;
    int unsigned total = 0;
    int unsigned cyc = 0;
    bit          mon = 1'b0;
    logic        exp_tx_q[$];
    logic        exp_busy_q[$];

    uart_tx_mmio #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (4),
        .DEFAULT_DIV (16'd868)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .hit        (hit),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    endtask

    // Expected line behaviour, one entry per clock after the pushing store.
    task automatic add_idle();
        exp_tx_q.push_back(1'b1);
        exp_busy_q.push_back(1'b0);
    endtask

    task automatic add_frame(input logic [7:0] b, input int d);
        int   slot;
        logic v;
        for (int i = 0; i < 10 * d; i++) begin
            slot = i / d;
            if (slot == 0)      v = 1'b0;
            else if (slot == 9) v = 1'b1;
            else                v = b[slot-1];
            exp_tx_q.push_back(v);
            exp_busy_q.push_back(1'b1);
        end
    endtask

    task automatic clear_model();
        exp_tx_q.delete();
        exp_busy_q.delete();
    endtask

    task automatic tick();
        logic et, eb;
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
        if (mon) begin
            et = (exp_tx_q.size() > 0) ? exp_tx_q.pop_front() : 1'b1;
            eb = (exp_busy_q.size() > 0) ? exp_busy_q.pop_front() : 1'b0;
            chk("tx_line", 32'(tx), 32'(et));
            chk("busy", 32'(busy), 32'(eb));
        end
    endtask

    task automatic drain(input int extra);
        int guard;
        guard = 0;
        while (exp_tx_q.size() > 0 && guard < 4000) begin
            tick();
            guard++;
        end
        repeat (extra) tick();
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        address    = BASE + 10'(off);
        write_data = d;
        MemWrite   = 1'b1;
        tick();
        MemWrite   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [9:0] a, input logic [31:0] e);
        address = a;
        MemRead = 1'b1;
        #1;
        chk(tag, read_data, e);
        MemRead = 1'b0;
    endtask

    // Load and store to the same register in one cycle; the load must see old state.
    task automatic wr_rd(input string tag, input logic [3:0] off, input logic [31:0] d,
                         input logic [31:0] e);
        address    = BASE + 10'(off);
        write_data = d;
        MemWrite   = 1'b1;
        MemRead    = 1'b1;
        #1;
        chk(tag, read_data, e);
        tick();
        MemWrite   = 1'b0;
        MemRead    = 1'b0;
    endtask

    initial begin
        int         d, n;
        logic [7:0] rb [4];

        RSTn = 1'b0;
        repeat (3) tick();
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        RSTn = 1'b1;
        tick();
        rd("reset_status", BASE + 10'd4, 32'h4);
        rd("reset_div", BASE + 10'd8, DEF_DIV);
        rd("txdata_read", BASE + 10'd0, 32'h0);

        address = 10'h000;
        MemRead = 1'b1;
        #1;
        chk("ram_hit", 32'(hit), 32'd0);
        chk("ram_rdata", read_data, 32'd0);
        address = BASE + 10'd12;
        #1;
        chk("rsvd_hit", 32'(hit), 32'd1);
        chk("rsvd_rdata", read_data, 32'd0);
        MemRead = 1'b0;
        address = BASE + 10'd8;
        #1;
        chk("noload_rdata", read_data, 32'd0);

        wr(4'h8, 32'd1);
        rd("div_clamp1", BASE + 10'd8, 32'd2);
        wr(4'h8, 32'd0);
        rd("div_clamp0", BASE + 10'd8, 32'd2);
        wr(4'hC, 32'hFFFF_FFFF);
        rd("rsvd_write", BASE + 10'd8, 32'd2);
        wr(4'h8, 32'hABCD_0004);
        rd("div_set4", BASE + 10'd8, 32'd4);

        // Single frame 0x55 at four clocks per bit.
        clear_model();
        add_idle();
        add_frame(8'h55, 4);
        mon = 1'b1;
        wr(4'h0, 32'h55);
        drain(3);

        // Six stores while idle: first pops, four queue, sixth is dropped.
        clear_model();
        add_idle();
        for (int k = 1; k <= 5; k++) add_frame(8'(k), 4);
        for (int k = 1; k <= 5; k++) wr(4'h0, 32'(k));
        rd("status_full", BASE + 10'd4, 32'h43);
        wr(4'h0, 32'h6);
        rd("status_ovf", BASE + 10'd4, 32'h4B);
        wr_rd("status_rw_pre", 4'h4, 32'h8, 32'h4B);
        rd("status_ovf_clr", BASE + 10'd4, 32'h43);
        drain(3);

        // Two queued bytes abut with no idle gap.
        clear_model();
        add_idle();
        add_frame(8'hA5, 4);
        add_frame(8'h3C, 4);
        wr(4'h0, 32'hA5);
        wr(4'h0, 32'h3C);
        drain(3);

        // DIV change mid-frame applies only to the following frame.
        clear_model();
        add_idle();
        add_frame(8'h96, 4);
        add_frame(8'h69, 8);
        wr(4'h0, 32'h96);
        repeat (10) tick();
        wr_rd("div_rw_pre", 4'h8, 32'd8, 32'd4);
        wr(4'h0, 32'h69);
        drain(3);
        mon = 1'b0;
        wr(4'h8, 32'd4);

        // Reset during data bit 3 with a second byte still queued.
        clear_model();
        add_idle();
        add_frame(8'h07, 4);
        add_frame(8'hF0, 4);
        mon = 1'b1;
        wr(4'h0, 32'h07);
        wr(4'h0, 32'hF0);
        repeat (17) tick();
        mon = 1'b0;
        clear_model();
        chk("pre_reset_bit3", 32'(tx), 32'd0);
        RSTn = 1'b0;
        tick();
        chk("mid_reset_tx", 32'(tx), 32'd1);
        chk("mid_reset_busy", 32'(busy), 32'd0);
        rd("mid_reset_status", BASE + 10'd4, 32'h4);
        rd("mid_reset_div", BASE + 10'd8, DEF_DIV);
        RSTn = 1'b1;
        mon = 1'b1;
        repeat (20) tick();
        mon = 1'b0;

        // Random divisors and byte bursts.
        for (int r = 0; r < 4; r++) begin
            d = int'($urandom_range(2, 5));
            n = int'($urandom_range(1, 4));
            wr(4'h8, 32'(d));
            rd("rand_div", BASE + 10'd8, 32'(d));
            clear_model();
            add_idle();
            for (int j = 0; j < n; j++) begin
                rb[j] = 8'($urandom);
                add_frame(rb[j], d);
            end
            mon = 1'b1;
            for (int j = 0; j < n; j++) wr(4'h0, 32'(rb[j]));
            drain(2);
            mon = 1'b0;
            rd("rand_status_idle", BASE + 10'd4, 32'h4);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
